// File: rtl/onehot_pulse_decoder_if.sv
// Handshake and strobe bundle for the one-hot pulse decoder.
// The decoder owns the slave side; the code source and strobe consumer use master.
interface onehot_pulse_decoder_if #(
    parameter int W = 3
);
    localparam int N = 2 ** W;

    logic         en;
    logic         in_valid;
    logic [W-1:0] in_code;
    logic         in_ready;
    logic [N-1:0] y;
    logic         busy;
    logic         done;
    logic [W-1:0] last_code;

    modport master (
        output en,
        output in_valid,
        output in_code,
        input  in_ready,
        input  y,
        input  busy,
        input  done,
        input  last_code
    );

    modport slave (
        input  en,
        input  in_valid,
        input  in_code,
        output in_ready,
        output y,
        output busy,
        output done,
        output last_code
    );
endinterface

// File: rtl/onehot_pulse_decoder.sv
// Sequential W:2**W decoder: each accepted code becomes a PULSE_LEN-cycle one-hot
// strobe on y, followed by GAP_LEN idle cycles before the next code is taken.
module onehot_pulse_decoder #(
    parameter int W         = 3,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    onehot_pulse_decoder_if.slave  bus,
    output logic [1:0]             o_dbg_state
);
    localparam int N = 2 ** W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    state_t       r_state;
    logic [7:0]   r_cnt;
    logic [N-1:0] r_y;
    logic         r_busy;
    logic         r_done;
    logic [W-1:0] r_last_code;

    state_t       w_state_nx;
    logic [7:0]   w_cnt_nx;
    logic [N-1:0] w_y_nx;
    logic         w_done_nx;
    logic [W-1:0] w_last_code_nx;
    logic         w_in_ready;
    logic         w_accept;

    // Handshake: a code transfers on a rising edge where in_valid and in_ready are
    // both 1; in_ready is combinational and never depends on in_valid.
    assign w_in_ready = rst_n & bus.en & (r_state == ST_IDLE);
    assign w_accept   = w_in_ready & bus.in_valid;

    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_y_nx         = r_y;
        w_done_nx      = 1'b0;
        w_last_code_nx = r_last_code;

        if (!bus.en) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = 8'd0;
            w_y_nx     = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_state_nx     = ST_ACTIVE;
                        w_y_nx         = N'(1) << bus.in_code;
                        w_last_code_nx = bus.in_code;
                        w_cnt_nx       = 8'(PULSE_LEN - 1);
                    end
                end
                ST_ACTIVE: begin
                    if (r_cnt == 8'd0) begin
                        w_y_nx    = '0;
                        w_done_nx = 1'b1;
                        if (GAP_LEN > 0) begin
                            w_state_nx = ST_GAP;
                            w_cnt_nx   = 8'(GAP_LEN - 1);
                        end else begin
                            w_state_nx = ST_IDLE;
                            w_cnt_nx   = 8'd0;
                        end
                    end else begin
                        w_cnt_nx = r_cnt - 8'd1;
                    end
                end
                ST_GAP: begin
                    w_y_nx = '0;
                    if (r_cnt == 8'd0) begin
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_cnt_nx = r_cnt - 8'd1;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = 8'd0;
                    w_y_nx     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_y         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_last_code <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_y         <= w_y_nx;
            r_busy      <= (w_state_nx != ST_IDLE);
            r_done      <= w_done_nx;
            r_last_code <= w_last_code_nx;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.y         = r_y;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.last_code = r_last_code;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Directed bench for onehot_pulse_decoder: a GAP_LEN=1 instance and a GAP_LEN=0
// instance share clock and reset and are driven through separate interfaces.
module tb_onehot_pulse_decoder;
    logic clk;
    logic rst_n;
    logic [1:0] dbg_state;
    logic [1:0] dbg_state0;
    int checks;
    int failures;
    int done_seen;

    onehot_pulse_decoder_if #(.W(3)) bus ();
    onehot_pulse_decoder_if #(.W(3)) bus0 ();

    onehot_pulse_decoder #(.W(3), .PULSE_LEN(4), .GAP_LEN(1)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    onehot_pulse_decoder #(.W(3), .PULSE_LEN(4), .GAP_LEN(0)) u_dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus0),
        .o_dbg_state (dbg_state0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_cnt();
        tick();
        if (bus.done === 1'b1) done_seen++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        done_seen = 0;
        rst_n         = 1'b0;
        bus.en        = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_code   = 3'd0;
        bus0.en       = 1'b1;
        bus0.in_valid = 1'b0;
        bus0.in_code  = 3'd0;

        // reset and idle
        tick();
        tick();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_y", bus.y, 0);
        rst_n = 1'b1;
        #1;
        chk("idle_y", bus.y, 8'h00);
        chk("idle_busy", bus.busy, 0);
        chk("idle_done", bus.done, 0);
        chk("idle_last", bus.last_code, 0);
        chk("idle_in_ready", bus.in_ready, 1);
        chk("idle_state", dbg_state, 0);

        // single pulse, code 5
        bus.in_valid = 1'b1;
        bus.in_code  = 3'd5;
        tick();
        bus.in_valid = 1'b0;
        chk("single_y_t1", bus.y, 8'h20);
        chk("single_last", bus.last_code, 5);
        chk("single_busy", bus.busy, 1);
        chk("single_ready_t1", bus.in_ready, 0);
        chk("single_state", dbg_state, 1);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("single_y_hold", bus.y, 8'h20);
            chk("single_nodone", bus.done, 0);
        end
        tick();
        chk("single_done_t5", bus.done, 1);
        chk("single_y_t5", bus.y, 8'h00);
        chk("single_ready_t5", bus.in_ready, 0);
        chk("single_state_gap", dbg_state, 2);
        tick();
        chk("single_done_t6", bus.done, 0);
        chk("single_ready_t6", bus.in_ready, 1);
        chk("single_busy_t6", bus.busy, 0);

        // full code sweep, in_valid held high
        bus.in_valid = 1'b1;
        bus.in_code  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            tick_cnt();
            chk("sweep_y_first", bus.y, 32'(1) << i);
            chk("sweep_last", bus.last_code, i);
            if (i < 7) bus.in_code = 3'(i + 1);
            else bus.in_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick_cnt();
                chk("sweep_y_hold", bus.y, 32'(1) << i);
                chk("sweep_ready_busy", bus.in_ready, 0);
            end
            tick_cnt();
            chk("sweep_y_off", bus.y, 0);
            tick_cnt();
            chk("sweep_ready_idle", bus.in_ready, 1);
        end
        chk("sweep_done_count", done_seen, 8);
        chk("sweep_last_final", bus.last_code, 7);

        // GAP_LEN=0 instance, codes 2 then 6 back-to-back
        bus0.in_valid = 1'b1;
        bus0.in_code  = 3'd2;
        tick();
        chk("gap0_y_first", bus0.y, 8'h04);
        bus0.in_code = 3'd6;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("gap0_y_hold", bus0.y, 8'h04);
        end
        tick();
        chk("gap0_y_off", bus0.y, 8'h00);
        chk("gap0_done", bus0.done, 1);
        chk("gap0_ready", bus0.in_ready, 1);
        tick();
        bus0.in_valid = 1'b0;
        chk("gap0_y_second", bus0.y, 8'h40);
        chk("gap0_last", bus0.last_code, 6);
        chk("gap0_done_clr", bus0.done, 0);
        repeat (4) tick();
        chk("gap0_done2", bus0.done, 1);
        tick();
        chk("gap0_idle", bus0.in_ready, 1);

        // abort during second ACTIVE cycle of code 7
        bus.in_valid = 1'b1;
        bus.in_code  = 3'd7;
        tick();
        bus.in_valid = 1'b0;
        chk("abort_y_t1", bus.y, 8'h80);
        tick();
        chk("abort_y_t2", bus.y, 8'h80);
        bus.en = 1'b0;
        #1;
        chk("abort_ready_en0", bus.in_ready, 0);
        tick();
        chk("abort_y", bus.y, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_last", bus.last_code, 7);
        chk("abort_ready", bus.in_ready, 0);
        chk("abort_state", dbg_state, 0);
        repeat (4) begin
            tick();
            chk("abort_no_done", bus.done, 0);
        end
        bus.en = 1'b1;
        #1;
        chk("abort_ready_en1", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_code  = 3'd3;
        tick();
        bus.in_valid = 1'b0;
        chk("post_abort_y", bus.y, 8'h08);
        chk("post_abort_last", bus.last_code, 3);
        repeat (3) tick();
        chk("post_abort_hold", bus.y, 8'h08);
        tick();
        chk("post_abort_done", bus.done, 1);
        tick();
        chk("post_abort_idle", bus.in_ready, 1);

        // asynchronous reset mid-pulse
        bus.in_valid = 1'b1;
        bus.in_code  = 3'd1;
        tick();
        bus.in_valid = 1'b0;
        chk("areset_pre_y", bus.y, 8'h02);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_y", bus.y, 0);
        chk("areset_busy", bus.busy, 0);
        chk("areset_done", bus.done, 0);
        chk("areset_last", bus.last_code, 0);
        chk("areset_ready", bus.in_ready, 0);
        chk("areset_state", dbg_state, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("areset_after_done", bus.done, 0);
        chk("areset_after_ready", bus.in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/onehot_pulse_decoder.md
Name: onehot_pulse_decoder

Overview:
- Sequential 3:8 decoder; the counterpart of the team's 8:3 priority encoder.
- Accepts an encoded index with a valid/ready handshake.
- Drives the matching one-hot line for a programmable number of cycles, then enforces a programmable idle gap before accepting the next index.
- Sits downstream of the encoder to regenerate one-hot strobes, such as grant or select lines.

Parameters:
- W, 3, code width; number of output lines is 2**W.
- PULSE_LEN, 4, cycles each one-hot output is held high; legal range 1..255.
- GAP_LEN, 1, idle cycles with y=0 after each pulse; legal range 0..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  block enable. When 0: abort the current operation, force outputs idle, refuse input.
- in_valid  input  1  in_code is valid this cycle.
- in_code  input  W  encoded index; bit position to assert on y.
- in_ready  output  1  decoder can accept a code this cycle.
- y  output  2**W  registered one-hot output; all zeros when not pulsing.
- busy  output  1  high in ACTIVE or GAP.
- done  output  1  single-cycle pulse marking pulse completion.
- last_code  output  W  most recently accepted code, held until the next accept.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, y=0, busy=0, done=0, last_code=0, counter=0. in_ready is combinational and is 0 while in reset.
- in_ready = en AND (state==IDLE).
- Accept: a code is accepted on a rising edge where in_valid=1 and in_ready=1.
  - At that edge: state becomes ACTIVE, y = 1 << in_code, last_code = in_code, counter = PULSE_LEN-1.
  - Latency: y is visible in the cycle after the accept edge.
- ACTIVE:
  - y holds its value; counter decrements each clock.
  - On the edge where counter==0:
    - y becomes 0, done=1 for one cycle.
    - If GAP_LEN>0: go to GAP with counter = GAP_LEN-1.
    - If GAP_LEN=0: go to IDLE.
  - Result: y is high for exactly PULSE_LEN cycles.
- GAP:
  - y=0; counter decrements each clock.
  - On the edge where counter==0: go to IDLE.
  - Result: the GAP state spans exactly GAP_LEN cycles.
- Throughput:
  - Back-to-back, one code is accepted every PULSE_LEN+GAP_LEN+1 cycles; the +1 is the IDLE accept cycle.
  - No input buffering. A held in_valid is not consumed until in_ready=1, and in_code must stay stable while waiting (source-side rule).
- done:
  - Asserted in the first cycle after the pulse ends, whether the next state is GAP or IDLE.
  - Never asserted on abort.
- en=0 (synchronous abort, takes priority over everything except reset):
  - At the next edge: state=IDLE, y=0, counter=0, done=0.
  - last_code is retained.
  - in_ready=0 combinationally while en=0.
- Mid-operation reset: asynchronous clear of all state, same values as the reset row above; no done pulse.
- in_code out of range is impossible for W bits; every code 0..2**W-1 is legal, and code 0 drives y[0].
- busy is registered and equals (state != IDLE).
- Counter width: 8 bits.

Test Plan:
- Reset/idle:
  - Stimulus: rst_n=0, then release with en=1 and in_valid=0.
  - Required response: y=8'h00, busy=0, done=0, last_code=0, in_ready=1.
- Single pulse (PULSE_LEN=4, GAP_LEN=1):
  - Stimulus: accept code 3'b101 at edge T.
  - Required response: y=8'b0010_0000 for cycles T+1..T+4. done=1 at T+5 with y=0. in_ready=0 at T+5, in_ready=1 at T+6.
- Full code sweep:
  - Stimulus: back-to-back codes 0..7 with in_valid held high.
  - Required response: y walks 8'h01..8'h80, each held 4 cycles. New accepts occur every 6 cycles; exactly 8 done pulses.
- GAP_LEN=0 build:
  - Stimulus: codes 2 then 6 back-to-back.
  - Required response: y=8'h04 for 4 cycles, one cycle of y=0 with done=1 and in_ready=1, then y=8'h40.
- Abort:
  - Stimulus: drop en to 0 during the second ACTIVE cycle of code 7.
  - Required response: y=0 at the next edge, no done pulse, last_code=7, in_ready=0 while en=0. After en returns to 1, a new code is accepted normally.
- Async reset mid-pulse:
  - Stimulus: assert rst_n=0 between clock edges during ACTIVE.
  - Required response: y=0 and busy=0 immediately, without waiting for a clock edge.
